// File: rtl/arith_scoreboard.sv
// Pipelined reference checker: computes expected add/sub/mul/max results, aligns them to DUT latency,
// and reports match/mismatch pulses, saturating counters and first-failure capture (ARITH_SCOREBOARD_CAPTURE_EN).
module arith_scoreboard #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned LATENCY = 1,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   input  logic [1:0]       i_mode,
   input  logic [WIDTH-1:0] i_dut_ia,
   input  logic [WIDTH-1:0] i_dut_ib,
   input  logic [WIDTH-1:0] i_dut_os,
   input  logic             i_clear,
   output logic             o_event,
   output logic             o_error,
   output logic             o_sticky_fail,
   output logic [CNT_W-1:0] o_pass_cnt,
   output logic [CNT_W-1:0] o_fail_cnt,
   output logic [WIDTH-1:0] o_first_fail_exp,
   output logic [WIDTH-1:0] o_first_fail_got
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0]   exp_c;
   logic [LATENCY-1:0] vld_q;
   logic [WIDTH-1:0]   pipe_q [LATENCY];
   logic               match_c;
   logic               mism_c;

   logic             event_q, event_d;
   logic             error_q, error_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] pass_q, pass_d;
   logic [CNT_W-1:0] fail_q, fail_d;

   // Reference model, all arithmetic modulo 2^WIDTH.
   always_comb begin
      exp_c = '0;
      case (i_mode)
         2'b00:   exp_c = i_dut_ia + i_dut_ib;
         2'b01:   exp_c = i_dut_ia - i_dut_ib;
         2'b10:   exp_c = WIDTH'(i_dut_ia * i_dut_ib);
         default: exp_c = (i_dut_ia > i_dut_ib) ? i_dut_ia : i_dut_ib;
      endcase
   end

   // Valid bits are cleared by reset so in-flight beats are discarded.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q[0] <= i_valid;
         for (int unsigned i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      pipe_q[0] <= exp_c;
      for (int unsigned i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
   end

   assign match_c = vld_q[LATENCY-1] && (pipe_q[LATENCY-1] == i_dut_os);
   assign mism_c  = vld_q[LATENCY-1] && (pipe_q[LATENCY-1] != i_dut_os);

   // Clear is applied first, then the outcome of the current comparison.
   always_comb begin
      event_d  = match_c;
      error_d  = mism_c;
      sticky_d = i_clear ? 1'b0 : sticky_q;
      pass_d   = i_clear ? '0 : pass_q;
      fail_d   = i_clear ? '0 : fail_q;
      if (match_c && (pass_d != CNT_MAX)) pass_d = pass_d + CNT_W'(1);
      if (mism_c && (fail_d != CNT_MAX))  fail_d = fail_d + CNT_W'(1);
      if (mism_c) sticky_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         event_q  <= 1'b0;
         error_q  <= 1'b0;
         sticky_q <= 1'b0;
         pass_q   <= '0;
         fail_q   <= '0;
      end else begin
         event_q  <= event_d;
         error_q  <= error_d;
         sticky_q <= sticky_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
      end
   end

`ifdef ARITH_SCOREBOARD_CAPTURE_EN
   logic [WIDTH-1:0] ff_exp_q, ff_exp_d;
   logic [WIDTH-1:0] ff_got_q, ff_got_d;
   logic             sticky_clr_c;

   // Capture loads only on the first mismatch after reset or clear.
   always_comb begin
      sticky_clr_c = i_clear ? 1'b0 : sticky_q;
      ff_exp_d     = i_clear ? '0 : ff_exp_q;
      ff_got_d     = i_clear ? '0 : ff_got_q;
      if (mism_c && !sticky_clr_c) begin
         ff_exp_d = pipe_q[LATENCY-1];
         ff_got_d = i_dut_os;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ff_exp_q <= '0;
         ff_got_q <= '0;
      end else begin
         ff_exp_q <= ff_exp_d;
         ff_got_q <= ff_got_d;
      end
   end

   assign o_first_fail_exp = ff_exp_q;
   assign o_first_fail_got = ff_got_q;
`else
   assign o_first_fail_exp = '0;
   assign o_first_fail_got = '0;
`endif

   assign o_event       = event_q;
   assign o_error       = error_q;
   assign o_sticky_fail = sticky_q;
   assign o_pass_cnt    = pass_q;
   assign o_fail_cnt    = fail_q;

endmodule

// File: tb/tb_arith_scoreboard.sv
// Directed bench for arith_scoreboard: three instances (latency 1, latency 3, narrow counters).
module tb_arith_scoreboard;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

`ifdef ARITH_SCOREBOARD_CAPTURE_EN
   localparam logic [31:0] EXP_FF_GOT = 32'd1;
`else
   localparam logic [31:0] EXP_FF_GOT = 32'd0;
`endif

   // Instance 1: WIDTH=32, LATENCY=1, CNT_W=16
   logic v1, clr1, ev1, er1, st1;
   logic [1:0] m1;
   logic [31:0] a1, b1, os1, fe1, fg1;
   logic [15:0] pc1, fc1;
   arith_scoreboard #(.WIDTH(32), .LATENCY(1), .CNT_W(16)) u1 (
      .clk(clk), .reset(reset), .i_valid(v1), .i_mode(m1), .i_dut_ia(a1), .i_dut_ib(b1),
      .i_dut_os(os1), .i_clear(clr1), .o_event(ev1), .o_error(er1), .o_sticky_fail(st1),
      .o_pass_cnt(pc1), .o_fail_cnt(fc1), .o_first_fail_exp(fe1), .o_first_fail_got(fg1));

   // Instance 3: WIDTH=32, LATENCY=3, CNT_W=16
   logic v3, clr3, ev3, er3, st3;
   logic [1:0] m3;
   logic [31:0] a3, b3, os3, fe3, fg3;
   logic [15:0] pc3, fc3;
   arith_scoreboard #(.WIDTH(32), .LATENCY(3), .CNT_W(16)) u3 (
      .clk(clk), .reset(reset), .i_valid(v3), .i_mode(m3), .i_dut_ia(a3), .i_dut_ib(b3),
      .i_dut_os(os3), .i_clear(clr3), .o_event(ev3), .o_error(er3), .o_sticky_fail(st3),
      .o_pass_cnt(pc3), .o_fail_cnt(fc3), .o_first_fail_exp(fe3), .o_first_fail_got(fg3));

   // Instance 4: WIDTH=8, LATENCY=1, CNT_W=4
   logic v4, clr4, ev4, er4, st4;
   logic [1:0] m4;
   logic [7:0] a4, b4, os4, fe4, fg4;
   logic [3:0] pc4, fc4;
   arith_scoreboard #(.WIDTH(8), .LATENCY(1), .CNT_W(4)) u4 (
      .clk(clk), .reset(reset), .i_valid(v4), .i_mode(m4), .i_dut_ia(a4), .i_dut_ib(b4),
      .i_dut_os(os4), .i_clear(clr4), .o_event(ev4), .o_error(er4), .o_sticky_fail(st4),
      .o_pass_cnt(pc4), .o_fail_cnt(fc4), .o_first_fail_exp(fe4), .o_first_fail_got(fg4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One LATENCY=1 transaction on u1: beat, then DUT result one cycle later.
   task automatic beat1(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] os, input logic clr);
      v1 = 1'b1; m1 = m; a1 = a; b1 = b; os1 = 32'hDEAD_BEEF;
      tick();
      v1 = 1'b0; os1 = os; clr1 = clr;
      tick();
      clr1 = 1'b0; os1 = 32'h1234_5678;
   endtask

   initial begin
      reset = 1'b1;
      {v1, clr1, m1, a1, b1, os1} = '0;
      {v3, clr3, m3, a3, b3, os3} = '0;
      {v4, clr4, m4, a4, b4, os4} = '0;
      tick(); tick();
      reset = 1'b0;
      check("rst_event", 64'(ev1), 64'd0);
      check("rst_error", 64'(er1), 64'd0);
      check("rst_sticky", 64'(st1), 64'd0);
      check("rst_pass", 64'(pc1), 64'd0);
      check("rst_fail", 64'(fc1), 64'd0);
      check("rst_ffexp", 64'(fe1), 64'd0);
      check("rst_pass4", 64'(pc4), 64'd0);

      // LATENCY=1 basic operations
      beat1(2'b00, 32'd5, 32'd3, 32'd8, 1'b0);
      check("add_event", 64'(ev1), 64'd1);
      check("add_error", 64'(er1), 64'd0);
      check("add_pass", 64'(pc1), 64'd1);
      tick();
      check("idle_event", 64'(ev1), 64'd0);
      check("idle_error", 64'(er1), 64'd0);

      beat1(2'b01, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
      check("sub_event", 64'(ev1), 64'd1);
      check("sub_pass", 64'(pc1), 64'd2);

      beat1(2'b10, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0);
      check("mul_event", 64'(ev1), 64'd1);
      check("mul_pass", 64'(pc1), 64'd3);

      beat1(2'b10, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);
      check("mulbad_error", 64'(er1), 64'd1);
      check("mulbad_event", 64'(ev1), 64'd0);
      check("mulbad_fail", 64'(fc1), 64'd1);
      check("mulbad_sticky", 64'(st1), 64'd1);
      check("mulbad_ffexp", 64'(fe1), 64'd0);
      check("mulbad_ffgot", 64'(fg1), 64'(EXP_FF_GOT));

      beat1(2'b11, 32'd7, 32'd9, 32'd9, 1'b0);
      check("max_event", 64'(ev1), 64'd1);
      check("max_pass", 64'(pc1), 64'd4);

      beat1(2'b11, 32'd20, 32'd3, 32'd5, 1'b0);
      check("max2_error", 64'(er1), 64'd1);
      check("max2_fail", 64'(fc1), 64'd2);
      check("max2_ffexp", 64'(fe1), 64'd0);
      check("max2_ffgot", 64'(fg1), 64'(EXP_FF_GOT));

      // Clear coincident with a mismatch outcome: clear first, then count it
      beat1(2'b00, 32'd1, 32'd1, 32'd3, 1'b1);
      check("clrmis_pass", 64'(pc1), 64'd0);
      check("clrmis_fail", 64'(fc1), 64'd1);
      check("clrmis_sticky", 64'(st1), 64'd1);
`ifdef ARITH_SCOREBOARD_CAPTURE_EN
      check("clrmis_ffexp", 64'(fe1), 64'd2);
      check("clrmis_ffgot", 64'(fg1), 64'd3);
`else
      check("clrmis_ffexp", 64'(fe1), 64'd0);
      check("clrmis_ffgot", 64'(fg1), 64'd0);
`endif

      // LATENCY=3: four back-to-back adds, third result wrong
      for (int cyc = 0; cyc < 9; cyc++) begin
         v3 = (cyc < 4);
         a3 = 32'(cyc + 1);
         b3 = 32'(cyc + 1);
         m3 = 2'b00;
         if (cyc >= 3 && cyc <= 6) os3 = 32'(2 * (cyc - 2)) + ((cyc == 5) ? 32'd1 : 32'd0);
         else os3 = 32'hFFFF_0000;
         tick();
         if (cyc >= 3 && cyc <= 6) begin
            check($sformatf("l3_event%0d", cyc - 3), 64'(ev3), (cyc == 5) ? 64'd0 : 64'd1);
            check($sformatf("l3_error%0d", cyc - 3), 64'(er3), (cyc == 5) ? 64'd1 : 64'd0);
         end else begin
            check($sformatf("l3_quiet%0d", cyc), 64'({ev3, er3}), 64'd0);
         end
      end
      check("l3_pass", 64'(pc3), 64'd3);
      check("l3_fail", 64'(fc3), 64'd1);

      // CNT_W=4: 20 matching beats saturate at 15
      for (int cyc = 0; cyc <= 20; cyc++) begin
         v4 = (cyc < 20);
         m4 = 2'b00;
         a4 = 8'(cyc);
         b4 = 8'd1;
         os4 = 8'(cyc);
         tick();
      end
      v4 = 1'b0;
      check("sat_pass", 64'(pc4), 64'd15);
      check("sat_fail", 64'(fc4), 64'd0);
      clr4 = 1'b1; v4 = 1'b1; a4 = 8'd10; b4 = 8'd5;
      tick();
      check("clr_pass", 64'(pc4), 64'd0);
      clr4 = 1'b0; v4 = 1'b0; os4 = 8'd15;
      tick();
      check("clr_inflight_event", 64'(ev4), 64'd1);
      check("clr_inflight_pass", 64'(pc4), 64'd1);

      // Reset with two beats in flight on LATENCY=3
      m3 = 2'b00; a3 = 32'd1; b3 = 32'd1; v3 = 1'b1;
      tick();
      a3 = 32'd2; b3 = 32'd2;
      tick();
      v3 = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 5; cyc++) begin
         os3 = (cyc == 0) ? 32'd2 : 32'd4;
         tick();
         check($sformatf("rst3_quiet%0d", cyc), 64'({ev3, er3}), 64'd0);
      end
      check("rst3_pass", 64'(pc3), 64'd0);
      check("rst3_fail", 64'(fc3), 64'd0);
      check("rst3_sticky", 64'(st3), 64'd0);
      check("rst3_ff", 64'({fe3, fg3}), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
